wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of write-back data.
REQ-002 Parameter REG_ADDR_W, default 4, register-file address width.
REQ-003 Parameter MAX_WAIT, default 3, maximum consecutive cycles the ALU requester may be stalled (range 1..15).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  pipeline flush; discards the pending ALU request for this cycle.
REQ-007 mem_valid  input  1  memory-load result available.
REQ-008 mem_rd  input  REG_ADDR_W  memory-load destination register.
REQ-009 mem_data  input  DATA_W  memory-load read data.
REQ-010 mem_ready  output  1  memory-load result accepted this cycle.
REQ-011 alu_valid  input  1  ALU result available.
REQ-012 alu_rd  input  REG_ADDR_W  ALU destination register.
REQ-013 alu_data  input  DATA_W  ALU result.
REQ-014 alu_ready  output  1  ALU result accepted this cycle.
REQ-015 rf_we  output  1  register-file write enable, registered.
REQ-016 rf_waddr  output  REG_ADDR_W  register-file write address, registered.
REQ-017 rf_wdata  output  DATA_W  register-file write data, registered.
REQ-018 alu_stall  output  1  high when alu_valid && !alu_ready, combinational.

Function
REQ-019 Transfer occurs on a requester when valid && ready in the same cycle; the requester SHALL hold valid, rd, and data stable until the transfer.
REQ-020 At most one transfer per cycle; mem_ready && alu_ready && mem_valid && alu_valid SHALL never be true together.
REQ-021 State machine SHALL have two states: MEM_PRIO and ALU_PRIO.
REQ-022 In MEM_PRIO: mem_ready = 1; alu_ready = !mem_valid && !flush.
REQ-023 In ALU_PRIO: alu_ready = !flush; mem_ready = !(alu_valid && !flush).
REQ-024 wait_cnt (4 bits) SHALL increment on each cycle with alu_valid && !alu_ready && !flush, saturating at MAX_WAIT.
REQ-025 The transition MEM_PRIO -> ALU_PRIO occurs on the edge at which wait_cnt becomes MAX_WAIT; the ALU is therefore stalled at most MAX_WAIT consecutive cycles.
REQ-026 The transition ALU_PRIO -> MEM_PRIO occurs on the edge following any ALU transfer, any flush, or any cycle with alu_valid = 0; wait_cnt clears on the same edge.
REQ-027 wait_cnt SHALL clear on any ALU transfer or flush.
REQ-028 Write latency is 1 cycle: on the edge after a transfer, rf_we = 1, rf_waddr = the transferred rd, and rf_wdata = the transferred data.
REQ-029 On cycles without a transfer, rf_we = 0 on the next edge; rf_waddr and rf_wdata hold their previous values.
REQ-030 A transfer with rd = 0 SHALL be accepted (ready asserted as normal), but rf_we stays 0 because r0 is hardwired to zero.
REQ-031 flush SHALL NOT affect memory-load acceptance in MEM_PRIO.

Reset
REQ-032 While reset = 0: state = MEM_PRIO, wait_cnt = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0.
REQ-033 A reset assertion mid-transfer SHALL drop the pending write; after release, the first edge behaves as in idle MEM_PRIO.

Structure
REQ-034 DATA_W/REG_ADDR_W defaults and the state enum {MEM_PRIO, ALU_PRIO} SHALL reside in shared package processor_pkg.
REQ-035 Starvation counting SHALL be one sub-module, wb_starve_counter (inputs inc, clr; output sat), instantiated once.
REQ-036 ready logic SHALL be combinational from state, valid, and flush; all other outputs SHALL be registered.

Verification
REQ-037 ALU only, alu_valid=1, alu_rd=5, alu_data=16'h1234 -> alu_ready=1 same cycle; next edge rf_we=1, rf_waddr=5, rf_wdata=16'h1234.
REQ-038 Both valid continuously, MAX_WAIT=3 -> mem accepted cycles 0-2, alu_ready=1 in cycle 3 only, mem_ready=0 in cycle 3, MEM_PRIO resumes cycle 4.
REQ-039 mem_valid=1, mem_rd=0, mem_data=16'hFFFF -> mem_ready=1; next edge rf_we=0.
REQ-040 Both valid with wait_cnt=2, flush=1 -> alu_ready=0, mem accepted, wait_cnt=0 next edge.
REQ-041 reset asserted asynchronously between edges during ALU_PRIO -> rf_we=0 and state MEM_PRIO immediately; no write occurs after release.
REQ-042 Random valid toggling for 10k cycles -> never two readies with both valids, ALU stall never exceeds MAX_WAIT, every accepted request written exactly once (r0 excluded).

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: default datapath widths and the write-back
// arbiter priority states.
package processor_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int WAIT_CNT_W     = 4;

  typedef enum logic {
    MEM_PRIO = 1'b0,
    ALU_PRIO = 1'b1
  } wbState_t;

endpackage

// File: rtl/wb_starve_counter.sv
// Counts consecutive cycles the ALU requester has been stalled, saturating at
// MAX_WAIT; sat flags the edge on which the count reaches MAX_WAIT.
module wb_starve_counter
  import processor_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] waitCnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (clr) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      waitCnt <= '0;
    end else if (inc && (waitCnt != MAX_CNT)) begin
      waitCnt <= waitCnt + WAIT_CNT_W'(1);
    end
  end

  // High when the coming edge leaves the count at MAX_WAIT.
  assign sat = inc && !clr && (waitCnt == (MAX_CNT - WAIT_CNT_W'(1)));

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter between the memory-load and ALU result
// paths: memory has priority until the ALU has waited MAX_WAIT cycles.
module wb_arbiter
  import processor_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  alu_stall
);

  wbState_t state;
  wbState_t nextState;
  logic     memXfer;
  logic     aluXfer;
  logic     starveInc;
  logic     starveClr;
  logic     starveSat;

  always_comb begin
    // NOTE: defaults first so every path assigns each output; otherwise a latch is inferred.
    mem_ready = 1'b1;
    alu_ready = 1'b0;
    unique case (state)
      MEM_PRIO: alu_ready = !mem_valid && !flush;
      ALU_PRIO: begin
        alu_ready = !flush;
        mem_ready = !(alu_valid && !flush);
      end
    endcase
  end

  assign memXfer   = mem_valid && mem_ready;
  assign aluXfer   = alu_valid && alu_ready;
  assign alu_stall = alu_valid && !alu_ready;

  // An absent ALU request also restarts the count: the next one is a new wait.
  assign starveInc = alu_valid && !alu_ready && !flush;
  assign starveClr = flush || aluXfer || !alu_valid;

  wb_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) uStarve (
    .clock(clock),
    .reset(reset),
    .inc  (starveInc),
    .clr  (starveClr),
    .sat  (starveSat)
  );

  // ALU priority lasts exactly one cycle: it ends in a transfer, a flush or an idle ALU.
  always_comb begin
    nextState = state;
    unique case (state)
      MEM_PRIO: if (starveSat) nextState = ALU_PRIO;
      ALU_PRIO: nextState = MEM_PRIO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= MEM_PRIO;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= nextState;
      // r0 is hardwired to zero, so its transfers complete without a write.
      rf_we <= (memXfer && (mem_rd != '0)) || (aluXfer && (alu_rd != '0));
      if (memXfer) begin
        rf_waddr <= mem_rd;
        rf_wdata <= mem_data;
      end else if (aluXfer) begin
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed priority/flush/r0/reset cases,
// then randomized traffic against a cycle-level reference model and scoreboard.
module tb_wb_arbiter;

  localparam int DW       = 16;
  localparam int AW       = 4;
  localparam int MAX_WAIT = 3;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   rd;
    logic [DW-1:0]   data;
  } wrExp_t;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          alu_stall;

  int     checks   = 0;
  int     failures = 0;
  int     edgeCnt  = 0;
  bit     monEn    = 0;
  wrExp_t expQ[$];

  // Reference model state: consecutive cycles the current ALU request waited.
  int stallRun = 0;
  int stallObs = 0;
  bit lastMemX;
  bit lastAluX;

  wb_arbiter #(
    .DATA_W    (DW),
    .REG_ADDR_W(AW),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .mem_valid(mem_valid),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .alu_stall(alu_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: each edge either retires the write expected from the
  // previous cycle or must show no write at all.
  initial begin
    wrExp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (monEn) begin
        if (expQ.size() != 0 && expQ[0].cyc == edgeCnt - 1) begin
          e = expQ.pop_front();
          check("write_en", 32'(rf_we), 32'd1);
          check("write_addr_data", {12'd0, rf_waddr, rf_wdata}, {12'd0, e.rd, e.data});
        end else begin
          check("no_write", 32'(rf_we), 32'd0);
        end
      end
    end
  end

  // Drives one cycle (called at posedge+1), checks handshakes against the
  // model, queues expected writes, and returns at the next posedge+1.
  task automatic step(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                      input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input logic fl, output logic memRdy, output logic aluRdy);
    bit aluTurn, expMem, expAlu;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    flush     = fl;
    #3;
    aluTurn = (stallRun >= MAX_WAIT);
    if (aluTurn) begin
      expAlu = !fl;
      expMem = !(av && !fl);
    end else begin
      expMem = 1'b1;
      expAlu = !mv && !fl;
    end
    memRdy = mem_ready;
    aluRdy = alu_ready;
    check("readies", {30'd0, mem_ready, alu_ready}, {30'd0, expMem, expAlu});
    check("alu_stall", 32'(alu_stall), 32'(av && !expAlu));
    check("one_grant", 32'(mem_valid && alu_valid && mem_ready && alu_ready), 32'd0);
    if (alu_valid && !alu_ready && !fl) begin
      stallObs++;
      check("stall_bound", 32'(stallObs <= MAX_WAIT), 32'd1);
    end else begin
      stallObs = 0;
    end
    lastMemX = mv && expMem;
    lastAluX = av && expAlu;
    if (lastMemX && mr != '0) expQ.push_back('{cyc: edgeCnt, rd: mr, data: md});
    if (lastAluX && ar != '0) expQ.push_back('{cyc: edgeCnt, rd: ar, data: ad});
    if (lastAluX || fl || !av) stallRun = 0;
    else stallRun++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic mr, ar;
    bit memPend, aluPend, fl;
    logic [AW-1:0] memRdR, aluRdR;
    logic [DW-1:0] memDataR, aluDataR;

    reset = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    #3;
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_addr_data", {12'd0, rf_waddr, rf_wdata}, 32'd0);
    check("reset_idle_readies", {30'd0, mem_ready, alu_ready}, 32'b11);
    #19;
    reset = 1'b1;
    monEn = 1;
    @(posedge clock);
    #1;

    // Both requesters continuously valid: ALU wins only after MAX_WAIT stalls.
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'(c + 1), 16'hA000 + 16'(c), 1'b1, 4'd7, 16'hBEEF, 1'b0, mr, ar);
      check($sformatf("prio_mem_c%0d", c), 32'(mr), 32'(c != 3));
      check($sformatf("prio_alu_c%0d", c), 32'(ar), 32'(c == 3));
    end
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'hBEEF, 1'b0, mr, ar);
    check("alu_alone", 32'(ar), 32'd1);

    // Flush after two stalls: memory still accepted, wait count restarts.
    step(1'b1, 4'd2, 16'h0002, 1'b1, 4'd9, 16'h0909, 1'b0, mr, ar);
    step(1'b1, 4'd3, 16'h0003, 1'b1, 4'd9, 16'h0909, 1'b0, mr, ar);
    step(1'b1, 4'd4, 16'h0004, 1'b1, 4'd9, 16'h0909, 1'b1, mr, ar);
    check("flush_mem_ready", 32'(mr), 32'd1);
    check("flush_alu_ready", 32'(ar), 32'd0);
    for (int d = 0; d < 4; d++) begin
      step(1'b1, 4'(d + 5), 16'h0100 + 16'(d), 1'b1, 4'd10, 16'h0A0A, 1'b0, mr, ar);
      check($sformatf("post_flush_alu_d%0d", d), 32'(ar), 32'(d == 3));
    end

    // ALU only: accepted at once, written one edge later.
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h1234, 1'b0, mr, ar);
    check("alu_only_ready", 32'(ar), 32'd1);
    check("alu_only_we", 32'(rf_we), 32'd1);
    check("alu_only_write", {12'd0, rf_waddr, rf_wdata}, {12'd0, 4'd5, 16'h1234});

    // r0 load is accepted but never written.
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0, 1'b0, mr, ar);
    check("r0_mem_ready", 32'(mr), 32'd1);
    check("r0_no_write", 32'(rf_we), 32'd0);

    // Reach ALU priority, then assert reset between edges.
    for (int c = 0; c < 3; c++)
      step(1'b1, 4'(c + 11), 16'h0C00 + 16'(c), 1'b1, 4'd6, 16'h6666, 1'b0, mr, ar);
    mem_valid = 1'b1; mem_rd = 4'd14; mem_data = 16'h0E0E;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 16'h6666; flush = 1'b0;
    #2;
    check("alu_prio_readies", {30'd0, mem_ready, alu_ready}, 32'b01);
    #1;
    monEn = 0;
    reset = 1'b0;
    #1;
    check("async_reset_we", 32'(rf_we), 32'd0);
    check("async_reset_state", {30'd0, mem_ready, alu_ready}, 32'b10);
    mem_valid = 1'b0; alu_valid = 1'b0;
    expQ.delete();
    stallRun = 0;
    stallObs = 0;
    @(posedge clock);
    @(posedge clock);
    #4;
    check("held_reset_we", 32'(rf_we), 32'd0);
    reset = 1'b1;
    monEn = 1;
    @(posedge clock);
    #1;
    check("post_reset_no_write", 32'(rf_we), 32'd0);

    // Randomized traffic; requesters hold their request until accepted,
    // and a flush discards the pending ALU request.
    memPend = 0; aluPend = 0;
    memRdR = '0; aluRdR = '0; memDataR = '0; aluDataR = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!memPend && $urandom_range(0, 99) < 55) begin
        memPend  = 1;
        memRdR   = 4'($urandom_range(0, 15));
        memDataR = 16'($urandom);
      end
      if (!aluPend && $urandom_range(0, 99) < 55) begin
        aluPend  = 1;
        aluRdR   = 4'($urandom_range(0, 15));
        aluDataR = 16'($urandom);
      end
      fl = ($urandom_range(0, 99) < 8);
      step(memPend, memRdR, memDataR, aluPend, aluRdR, aluDataR, fl, mr, ar);
      if (lastMemX) memPend = 0;
      if (lastAluX || fl) aluPend = 0;
    end

    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, mr, ar);
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, mr, ar);
    check("queue_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
